// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: byte width, drain FSM states and
// the saturating helper used by the optional dropped-push counter.
package uart_tx_queue_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DONE  = 2'd2
    } drain_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/uart_tx_queue_sync_fifo_mem.sv
// Byte register file for the transmit queue: one synchronous write port and one
// asynchronous read port, so a pop sees the entry before a same-cycle overwrite.
module sync_fifo_mem
    import uart_tx_queue_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = BYTE_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO between the UART memory controller and the UART transmitter, paced on
// uart_is_transmitting. Define UART_TX_QUEUE_OVF_CNT_EN to add the ovf_count port.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2    = 4,
    parameter int START_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [BYTE_W-1:0]     push_byte,
    output logic                  uart_transmit,
    output logic [BYTE_W-1:0]     uart_tx_byte,
    input  logic                  uart_is_transmitting,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
`ifdef UART_TX_QUEUE_OVF_CNT_EN
    ,
    output logic [7:0]            ovf_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int TMR_W = $clog2(START_TIMEOUT + 1);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [BYTE_W-1:0]     rd_data;
    logic [TMR_W-1:0]      timer;
    drain_state_t          state;

    logic pop;
    logic push_ok;
    logic drop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A pop frees a slot in the same cycle, so a push into a full queue is only
    // dropped when no byte leaves on that edge.
    assign pop     = (state == IDLE) && !empty && !uart_is_transmitting;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    sync_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (BYTE_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (push_byte),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef UART_TX_QUEUE_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= 8'h00;
        end else if (drop) begin
            ovf_count <= sat_inc8(ovf_count);
        end
    end
`endif

    // Drain FSM: launch one byte, then wait for the UART to take it (or give up
    // after START_TIMEOUT cycles) and for the frame to finish before the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            timer         <= '0;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    uart_transmit <= 1'b0;
                    if (pop) begin
                        uart_tx_byte  <= rd_data;
                        uart_transmit <= 1'b1;
                        rd_ptr        <= rd_ptr + 1'b1;
                        timer         <= '0;
                        state         <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    uart_transmit <= 1'b0;
                    if (uart_is_transmitting) begin
                        state <= WAIT_DONE;
                    end else if (timer == TMR_W'(START_TIMEOUT - 1)) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    uart_transmit <= 1'b0;
                    if (!uart_is_transmitting) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    uart_transmit <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed testbench for uart_tx_queue with a small UART responder model.
// Define UART_TX_QUEUE_OVF_CNT_EN to also exercise the ovf_count port.
module tb_uart_tx_queue;

    localparam int DEPTH_LOG2 = 4;
    localparam int CNT_W      = DEPTH_LOG2 + 1;

    logic             clk;
    logic             rst_n;
    logic             push;
    logic [7:0]       push_byte;
    logic             uart_transmit;
    logic [7:0]       uart_tx_byte;
    logic             uart_is_transmitting;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
`ifdef UART_TX_QUEUE_OVF_CNT_EN
    logic [7:0]       ovf_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // UART model: mode 0 = busy 1 cycle after strobe for 10 cycles,
    // mode 1 = never busy, mode 2 = busy held high.
    int         uart_mode = 1;
    int         busy_cnt  = 0;
    int         cyc       = 0;
    int         strobes   = 0;
    int         consec_err = 0;
    logic       prev_tx   = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         strobe_cyc[$];

    uart_tx_queue #(
        .DEPTH_LOG2    (DEPTH_LOG2),
        .START_TIMEOUT (4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .push                 (push),
        .push_byte            (push_byte),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .full                 (full),
        .empty                (empty),
        .count                (count),
        .overflow             (overflow)
`ifdef UART_TX_QUEUE_OVF_CNT_EN
        ,
        .ovf_count            (ovf_count)
`endif
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        uart_is_transmitting = 1'b0;
    end

    always @(negedge clk) begin
        cyc++;
        if (uart_transmit) begin
            got_q.push_back(uart_tx_byte);
            strobe_cyc.push_back(cyc);
            strobes++;
            if (prev_tx) consec_err++;
        end
        prev_tx = uart_transmit;
        case (uart_mode)
            2: begin busy_cnt = 0; uart_is_transmitting = 1'b1; end
            1: begin busy_cnt = 0; uart_is_transmitting = 1'b0; end
            default: begin
                if (uart_transmit) busy_cnt = 10;
                else if (busy_cnt > 0) busy_cnt--;
                uart_is_transmitting = (busy_cnt != 0);
            end
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int mode_after);
        uart_mode = 1;
        push = 1'b0;
        tick(2);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        uart_mode = mode_after;
        tick(1);
        exp_q.delete();
        got_q.delete();
        strobe_cyc.delete();
    endtask

    task automatic push_one(input logic [7:0] b);
        push = 1'b1;
        push_byte = b;
        tick(1);
        push = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget);
        int w;
        w = 0;
        while (got_q.size() < n && w < budget) begin
            tick(1);
            w++;
        end
        tick(15);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        push = 1'b0;
        push_byte = 8'h00;
        tick(3);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (uart_transmit !== 1'b0) begin n_fail++; $display("FAIL reset_transmit: got %b expected 0", uart_transmit); end
        n_checks++; if (uart_tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h expected 00", uart_tx_byte); end
        rst_n = 1'b1;
        uart_mode = 0;
        tick(2);
    endtask

    task automatic test_single();
        exp_q.delete(); got_q.delete();
        exp_q.push_back(8'h41);
        push_one(8'h41);
        n_checks++; if (uart_transmit !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b expected 0", uart_transmit); end
        n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", count); end
        tick(1);
        n_checks++; if (uart_transmit !== 1'b1) begin n_fail++; $display("FAIL single_latency: got %b expected 1", uart_transmit); end
        n_checks++; if (uart_tx_byte !== 8'h41) begin n_fail++; $display("FAIL single_byte: got %h expected 41", uart_tx_byte); end
        tick(1);
        n_checks++; if (uart_transmit !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0", uart_transmit); end
        n_checks++; if (uart_tx_byte !== 8'h41) begin n_fail++; $display("FAIL single_byte_held: got %h expected 41", uart_tx_byte); end
        tick(20);
        n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", got_q.size()); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b expected 1", empty); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL single_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_fill_overflow();
        exp_q.delete(); got_q.delete();
        uart_mode = 2;
        tick(1);
        for (int i = 1; i <= 16; i++) begin
            push = 1'b1;
            push_byte = 8'(i);
            exp_q.push_back(8'(i));
            tick(1);
        end
        push = 1'b0;
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d expected 16", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_overflow: got %b expected 0", overflow); end
        push_one(8'hEE);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %b expected 1", overflow); end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count_after_drop: got %0d expected 16", count); end
        uart_mode = 0;
        wait_got(16, 600);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL fill_drain_size: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fill_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty_after: got %b expected 1", empty); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_push_pop_full();
        do_reset(2);
        for (int i = 0; i < 16; i++) begin
            push = 1'b1;
            push_byte = 8'h20 + 8'(i);
            exp_q.push_back(8'h20 + 8'(i));
            tick(1);
        end
        push = 1'b0;
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL pp_full: got %b expected 1", full); end
        uart_mode = 0;
        tick(1);
        push = 1'b1;
        push_byte = 8'h5A;
        exp_q.push_back(8'h5A);
        tick(1);
        push = 1'b0;
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL pp_count: got %0d expected 16", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
        n_checks++; if (uart_tx_byte !== 8'h20) begin n_fail++; $display("FAIL pp_first_byte: got %h expected 20", uart_tx_byte); end
        wait_got(17, 700);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL pp_drain_size: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pp_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow_end: got %b expected 0", overflow); end
    endtask

    task automatic test_timeout();
        do_reset(1);
        push = 1'b1; push_byte = 8'h77; tick(1);
        push_byte = 8'h88; tick(1);
        push = 1'b0;
        tick(30);
        n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL timeout_pulses: got %0d expected 2", got_q.size()); end
        if (got_q.size() >= 2 && strobe_cyc.size() >= 2) begin
            n_checks++; if (got_q[0] !== 8'h77) begin n_fail++; $display("FAIL timeout_byte0: got %h expected 77", got_q[0]); end
            n_checks++; if (got_q[1] !== 8'h88) begin n_fail++; $display("FAIL timeout_byte1: got %h expected 88", got_q[1]); end
            n_checks++; if (strobe_cyc[1] - strobe_cyc[0] !== 5) begin n_fail++; $display("FAIL timeout_gap: got %0d expected 5", strobe_cyc[1] - strobe_cyc[0]); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL timeout_empty: got %b expected 1", empty); end
    endtask

    task automatic test_reset_mid_frame();
        int strobes_before;
        do_reset(0);
        for (int i = 0; i < 6; i++) begin
            push = 1'b1;
            push_byte = 8'h90 + 8'(i);
            tick(1);
        end
        push = 1'b0;
        n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL midrst_count_before: got %0d expected 5", count); end
        n_checks++; if (uart_is_transmitting !== 1'b1) begin n_fail++; $display("FAIL midrst_frame_busy: got %b expected 1", uart_is_transmitting); end
        strobes_before = strobes;
        rst_n = 1'b0;
        #1;
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty: got %b expected 1", empty); end
        n_checks++; if (uart_transmit !== 1'b0) begin n_fail++; $display("FAIL midrst_transmit: got %b expected 0", uart_transmit); end
        n_checks++; if (uart_tx_byte !== 8'h00) begin n_fail++; $display("FAIL midrst_tx_byte: got %h expected 00", uart_tx_byte); end
        tick(2);
        rst_n = 1'b1;
        tick(40);
        n_checks++; if (strobes !== strobes_before) begin n_fail++; $display("FAIL midrst_no_pulses: got %0d expected %0d", strobes, strobes_before); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty_after: got %b expected 1", empty); end
    endtask

`ifdef UART_TX_QUEUE_OVF_CNT_EN
    task automatic test_ovf_count();
        do_reset(2);
        n_checks++; if (ovf_count !== 8'h00) begin n_fail++; $display("FAIL ovfcnt_reset: got %h expected 00", ovf_count); end
        push = 1'b1;
        for (int i = 0; i < 21; i++) begin
            push_byte = 8'(i);
            tick(1);
        end
        n_checks++; if (ovf_count !== 8'h05) begin n_fail++; $display("FAIL ovfcnt_five: got %h expected 05", ovf_count); end
        for (int i = 21; i < 300; i++) begin
            push_byte = 8'(i);
            tick(1);
        end
        push = 1'b0;
        n_checks++; if (ovf_count !== 8'hFF) begin n_fail++; $display("FAIL ovfcnt_saturate: got %h expected FF", ovf_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovfcnt_sticky: got %b expected 1", overflow); end
    endtask
`endif

    initial begin
        push = 1'b0;
        push_byte = 8'h00;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_push_pop_full();
        test_timeout();
        test_reset_mid_frame();
`ifdef UART_TX_QUEUE_OVF_CNT_EN
        test_ovf_count();
`endif
        n_checks++; if (consec_err !== 0) begin n_fail++; $display("FAIL back_to_back_strobe: got %0d expected 0", consec_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
